mac_feed_scheduler: RTL and testbench

MAC_FEED_SCHEDULER -- requirements
Module: mac_feed_scheduler

---
 rtl/cnn_sched_pkg.sv | 21 ++
 rtl/mac_wt_loader.sv | 87 ++++++++
 rtl/mac_feed_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_mac_feed_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cnn_sched_pkg.sv
// rtl/cnn_sched_pkg.sv - shared states and default sizing for the MAC feed scheduler
package cnn_sched_pkg;

    localparam int DEF_TOUT      = 32;
    localparam int DEF_LOG2TOUT  = 5;
    localparam int DEF_DRAIN_CYC = 8;

    typedef enum logic [1:0] {
        W_IDLE,
        W_LOAD,
        W_HOLD
    } wt_state_e;

    typedef enum logic [1:0] {
        D_IDLE,
        D_WAIT,
        D_STREAM,
        D_DRAIN
    } dat_state_e;

endpackage

// File: rtl/mac_wt_loader.sv
// rtl/mac_wt_loader.sv - weight engine: loads one group of TOUT rows, then holds until granted
module mac_wt_loader
    import cnn_sched_pkg::*;
#(
    parameter int TOUT     = DEF_TOUT,
    parameter int LOG2TOUT = DEF_LOG2TOUT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     clear_i,
    input  logic                     stall_i,
    input  logic                     grant_i,
    input  logic [11:0]              groups_i,
    output logic                     rd_en_o,
    output logic [11+LOG2TOUT:0]     rd_addr_o,
    output logic [LOG2TOUT-1:0]      row_o
);

    wt_state_e              state_q, state_d;
    logic [11:0]            grp_q, grp_d;
    logic [LOG2TOUT-1:0]    row_q, row_d;
    logic                   tok_q, tok_d;

    // Engine state, group/row counters and the one-group-ahead token
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= W_IDLE;
            grp_q   <= '0;
            row_q   <= '0;
            tok_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            row_q   <= row_d;
            tok_q   <= tok_d;
        end
    end

    // Next state: a grant (Wout_loop_start of the group in use) lets the next group load
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        row_d   = row_q;
        tok_d   = tok_q | grant_i;
        rd_en_o = 1'b0;
        case (state_q)
            W_IDLE: begin
                tok_d = 1'b0;
                if (start_i) begin
                    state_d = W_LOAD;
                    grp_d   = '0;
                    row_d   = '0;
                end
            end
            W_LOAD: begin
                if (!stall_i) begin
                    rd_en_o = 1'b1;
                    if (row_q == LOG2TOUT'(TOUT - 1)) begin
                        row_d   = '0;
                        state_d = W_HOLD;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            W_HOLD: begin
                if ((grp_q != groups_i - 12'd1) && (tok_q || grant_i)) begin
                    state_d = W_LOAD;
                    grp_d   = grp_q + 12'd1;
                    tok_d   = 1'b0;
                end
            end
            default: state_d = W_IDLE;
        endcase
        if (clear_i) begin
            state_d = W_IDLE;
            grp_d   = '0;
            row_d   = '0;
            tok_d   = 1'b0;
        end
    end

    assign rd_addr_o = rd_en_o ? {grp_q, row_q} : '0;
    assign row_o     = row_q;

endmodule

// File: rtl/mac_feed_scheduler.sv
// rtl/mac_feed_scheduler.sv - data engine, weight loader and MAC-side pipeline registers
module mac_feed_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int TOUT      = DEF_TOUT,
    parameter int LOG2TOUT  = DEF_LOG2TOUT,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [15:0]              cfg_wout,
    input  logic [11:0]              cfg_groups,
    input  logic                     stall,
    output logic                     busy,
    output logic                     done,
    output logic                     wt_rd_en,
    output logic [11+LOG2TOUT:0]     wt_rd_addr,
    output logic                     dat_rd_en,
    output logic [15:0]              dat_rd_addr,
    output logic                     wt_vld,
    output logic [LOG2TOUT-1:0]      wt_cnt,
    output logic                     dat_vld,
    output logic                     Wout_loop_start,
    output logic                     Wout_loop_end
);

    localparam int DW = $clog2(DRAIN_CYC + 1);

    dat_state_e             dstate_q, dstate_d;
    logic [15:0]            wout_q, wout_d;
    logic [11:0]            groups_q, groups_d;
    logic [15:0]            pix_q, pix_d;
    logic [11:0]            dgrp_q, dgrp_d;
    logic [DW-1:0]          drain_q, drain_d;
    logic                   ready_q, ready_d;

    logic                   wt_vld_q, dat_vld_q, wls_q, wle_q;
    logic [LOG2TOUT-1:0]    wt_cnt_q;
    logic [LOG2TOUT-1:0]    wt_row;
    logic                   accept, zero_cfg, wt_done, clear;

    assign accept   = start && (dstate_q == D_IDLE);
    assign zero_cfg = (cfg_wout == 16'd0) || (cfg_groups == 12'd0);
    assign wt_done  = wt_vld_q && (wt_cnt_q == LOG2TOUT'(TOUT - 1));

    mac_wt_loader #(
        .TOUT     (TOUT),
        .LOG2TOUT (LOG2TOUT)
    ) u_wt_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept && !zero_cfg),
        .clear_i   (clear),
        .stall_i   (stall),
        .grant_i   (wls_q),
        .groups_i  (groups_q),
        .rd_en_o   (wt_rd_en),
        .rd_addr_o (wt_rd_addr),
        .row_o     (wt_row)
    );

    // Data engine state, sampled configuration and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dstate_q <= D_IDLE;
            wout_q   <= '0;
            groups_q <= '0;
            pix_q    <= '0;
            dgrp_q   <= '0;
            drain_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            dstate_q <= dstate_d;
            wout_q   <= wout_d;
            groups_q <= groups_d;
            pix_q    <= pix_d;
            dgrp_q   <= dgrp_d;
            drain_q  <= drain_d;
            ready_q  <= ready_d;
        end
    end

    // Data engine: ready marks a fully loaded group waiting to be streamed
    always_comb begin
        dstate_d  = dstate_q;
        wout_d    = wout_q;
        groups_d  = groups_q;
        pix_d     = pix_q;
        dgrp_d    = dgrp_q;
        drain_d   = drain_q;
        ready_d   = ready_q | wt_done;
        dat_rd_en = 1'b0;
        done      = 1'b0;
        clear     = 1'b0;
        case (dstate_q)
            D_IDLE: begin
                ready_d = 1'b0;
                if (accept) begin
                    wout_d   = cfg_wout;
                    groups_d = cfg_groups;
                    pix_d    = '0;
                    dgrp_d   = '0;
                    if (zero_cfg) begin
                        // Preset so the final count lands two cycles after start
                        dstate_d = D_DRAIN;
                        drain_d  = DW'(DRAIN_CYC - 1);
                    end else begin
                        dstate_d = D_WAIT;
                    end
                end
            end
            D_WAIT: begin
                if (ready_d) begin
                    dstate_d = D_STREAM;
                    ready_d  = 1'b0;
                end
            end
            D_STREAM: begin
                if (!stall) begin
                    dat_rd_en = 1'b1;
                    if (pix_q == wout_q - 16'd1) begin
                        pix_d = '0;
                        if (dgrp_q == groups_q - 12'd1) begin
                            dstate_d = D_DRAIN;
                            drain_d  = '0;
                        end else begin
                            dgrp_d = dgrp_q + 12'd1;
                            if (ready_d) begin
                                ready_d = 1'b0;
                            end else begin
                                dstate_d = D_WAIT;
                            end
                        end
                    end else begin
                        pix_d = pix_q + 16'd1;
                    end
                end
            end
            D_DRAIN: begin
                if (drain_q == DW'(DRAIN_CYC)) begin
                    done     = 1'b1;
                    clear    = 1'b1;
                    dstate_d = D_IDLE;
                    wout_d   = '0;
                    groups_d = '0;
                    dgrp_d   = '0;
                    drain_d  = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: dstate_d = D_IDLE;
        endcase
    end

    // MAC-side beats: each read strobe delayed by the one-cycle buffer latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_vld_q  <= 1'b0;
            wt_cnt_q  <= '0;
            dat_vld_q <= 1'b0;
            wls_q     <= 1'b0;
            wle_q     <= 1'b0;
        end else begin
            wt_vld_q  <= wt_rd_en;
            wt_cnt_q  <= wt_rd_en ? wt_row : '0;
            dat_vld_q <= dat_rd_en;
            wls_q     <= dat_rd_en && (pix_q == 16'd0);
            wle_q     <= dat_rd_en && (pix_q == wout_q - 16'd1);
        end
    end

    assign busy            = (dstate_q != D_IDLE);
    assign dat_rd_addr     = dat_rd_en ? pix_q : '0;
    assign wt_vld          = wt_vld_q;
    assign wt_cnt          = wt_cnt_q;
    assign dat_vld         = dat_vld_q;
    assign Wout_loop_start = wls_q;
    assign Wout_loop_end   = wle_q;

endmodule

// File: tb/tb_mac_feed_scheduler.sv
// tb/tb_mac_feed_scheduler.sv - directed self-checking bench for mac_feed_scheduler
module tb_mac_feed_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] cfg_wout;
    logic [11:0] cfg_groups;
    logic        stall;
    logic        busy, done, wt_rd_en, dat_rd_en, wt_vld, dat_vld, wls, wle;
    logic [13:0] wt_rd_addr;
    logic [15:0] dat_rd_addr;
    logic [1:0]  wt_cnt;
    logic [63:0] outs;

    logic [63:0] busy_v, done_v, wtv_v, datv_v, ws_v, we_v, wtc_s, wta_s, daa_s;
    int          nwt, ndat;
    int          checks, failures;

    mac_feed_scheduler #(
        .TOUT      (4),
        .LOG2TOUT  (2),
        .DRAIN_CYC (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfg_wout        (cfg_wout),
        .cfg_groups      (cfg_groups),
        .stall           (stall),
        .busy            (busy),
        .done            (done),
        .wt_rd_en        (wt_rd_en),
        .wt_rd_addr      (wt_rd_addr),
        .dat_rd_en       (dat_rd_en),
        .dat_rd_addr     (dat_rd_addr),
        .wt_vld          (wt_vld),
        .wt_cnt          (wt_cnt),
        .dat_vld         (dat_vld),
        .Wout_loop_start (wls),
        .Wout_loop_end   (wle)
    );

    assign outs = {24'd0, busy, done, wt_rd_en, wt_rd_addr, dat_rd_en, dat_rd_addr,
                   wt_vld, wt_cnt, dat_vld, wls, wle};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bitm(input int n);
        return 64'd1 << n;
    endfunction

    // One tile of 64 cycles; cycle 0 is the cycle start is high
    task automatic run(input int wout, input int groups, input int slo, input int shi,
                       input int xa, input int xb, input int rst_at);
        busy_v = '0; done_v = '0; wtv_v = '0; datv_v = '0; ws_v = '0; we_v = '0;
        wtc_s = '0; wta_s = '0; daa_s = '0; nwt = 0; ndat = 0;
        cfg_wout   = 16'(wout);
        cfg_groups = 12'(groups);
        for (int rel = 0; rel < 64; rel++) begin
            @(posedge clk);
            #1;
            start = (rel == 0) || (rel == xa) || (rel == xb);
            stall = (rel >= slo) && (rel <= shi);
            if (rel == rst_at) begin
                chk("pre_rst_rd", 64'(wt_rd_en), 64'd1);
                rst_n = 1'b0;
                #1;
                chk("rst_async", outs, 64'd0);
                #4;
            end else begin
                rst_n = 1'b1;
                #5;
            end
            busy_v[rel] = busy;
            done_v[rel] = done;
            wtv_v[rel]  = wt_vld;
            datv_v[rel] = dat_vld;
            ws_v[rel]   = wls;
            we_v[rel]   = wle;
            if (wt_vld)    wtc_s = {wtc_s[59:0], 2'b00, wt_cnt};
            if (wt_rd_en)  begin wta_s = {wta_s[59:0], wt_rd_addr[3:0]}; nwt++; end
            if (dat_rd_en) begin daa_s = {daa_s[59:0], dat_rd_addr[3:0]}; ndat++; end
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic check_base(input string tag);
        chk({tag, "_busy"}, busy_v, rng(1, 27));
        chk({tag, "_done"}, done_v, bitm(27));
        chk({tag, "_wtvld"}, wtv_v, rng(2, 5) | rng(9, 12));
        chk({tag, "_wtcnt"}, wtc_s, 64'h0000_0000_0123_0123);
        chk({tag, "_wtaddr"}, wta_s, 64'h0000_0000_0123_4567);
        chk({tag, "_datvld"}, datv_v, rng(7, 12) | rng(14, 19));
        chk({tag, "_wls"}, ws_v, bitm(7) | bitm(14));
        chk({tag, "_wle"}, we_v, bitm(12) | bitm(19));
        chk({tag, "_dataddr"}, daa_s, 64'h0000_0123_4501_2345);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; cfg_wout = '0; cfg_groups = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs, 64'd0);

        run(6, 2, -1, -1, -1, -1, -1);
        check_base("base");

        run(8, 2, -1, -1, -1, -1, -1);
        chk("b2b_datvld", datv_v, rng(7, 22));
        chk("b2b_wle", we_v, bitm(14) | bitm(22));
        chk("b2b_done", done_v, bitm(30));
        chk("b2b_dataddr", daa_s, 64'h0123_4567_0123_4567);

        run(6, 2, 8, 10, -1, -1, -1);
        chk("stall_dataddr", daa_s, 64'h0000_0123_4501_2345);
        chk("stall_datvld", datv_v, rng(7, 8) | rng(12, 15) | rng(17, 22));
        chk("stall_wtvld", wtv_v, rng(2, 5) | rng(12, 15));
        chk("stall_wle", we_v, bitm(15) | bitm(22));
        chk("stall_wls", ws_v, bitm(7) | bitm(17));
        chk("stall_done", done_v, bitm(30));
        chk("stall_busy", busy_v, rng(1, 30));

        run(6, 0, -1, -1, -1, -1, -1);
        chk("g0_done", done_v, bitm(2));
        chk("g0_busy", busy_v, rng(1, 2));
        chk("g0_reads", 64'(nwt + ndat), 64'd0);

        run(0, 2, -1, -1, -1, -1, -1);
        chk("w0_done", done_v, bitm(2));
        chk("w0_reads", 64'(nwt + ndat), 64'd0);

        run(6, 2, -1, -1, -1, -1, 10);
        chk("rst_no_done", done_v, 64'd0);
        run(6, 2, -1, -1, -1, -1, -1);
        check_base("rerun");

        run(6, 2, -1, -1, 5, 27, -1);
        chk("restart_wtreads", 64'(nwt), 64'd8);
        chk("restart_datreads", 64'(ndat), 64'd12);
        chk("restart_busy", busy_v, rng(1, 27));
        chk("restart_done", done_v, bitm(27));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
